// File: rtl/mempool_dma_scheduler_pkg.sv
// Shared types and width helpers for the MemPool DMA scheduler.
package mempool_dma_scheduler_pkg;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] num_bytes;
    } burst_req_t;

    // Requester index width; a single requester still gets one bit.
    function automatic int unsigned idx_width(int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int unsigned cnt_width(int unsigned max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage

// File: rtl/mempool_dma_scheduler_if.sv
// Backend burst channel between the scheduler (master) and the DMA backend (slave).
interface mempool_dma_scheduler_if;
    import mempool_dma_scheduler_pkg::*;

    burst_req_t burst_req;
    logic       valid;
    logic       ready;
    logic       trans_complete;
    logic       backend_idle;

    modport master (
        output burst_req,
        output valid,
        input  ready,
        input  trans_complete,
        input  backend_idle
    );

    modport slave (
        input  burst_req,
        input  valid,
        output ready,
        output trans_complete,
        output backend_idle
    );
endinterface

// File: rtl/mempool_dma_sched_fifo.sv
// In-order FIFO of requester indices for issued-but-incomplete backend transfers.
module mempool_dma_sched_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth = $clog2(Depth + 1);

    logic [Width-1:0]    mem_q [Depth];
    logic [PtrWidth-1:0] wptr_q, rptr_q;
    logic [CntWidth-1:0] cnt_q;
    logic                do_push, do_pop;

    function automatic logic [PtrWidth-1:0] ptr_inc(logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CntWidth'(Depth));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= ptr_inc(wptr_q);
            if (do_pop)  rptr_q <= ptr_inc(rptr_q);
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!do_push && do_pop) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mempool_dma_scheduler.sv
// Round-robin sharing of one MemPool DMA backend between NumReq frontends,
// with in-order completion tracking and per-requester done pulses.
module mempool_dma_scheduler
    import mempool_dma_scheduler_pkg::*;
#(
    parameter int unsigned NumReq         = 4,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  burst_req_t              req_burst_i [NumReq],
    input  logic [NumReq-1:0]       req_valid_i,
    output logic [NumReq-1:0]       req_ready_o,
    output logic [NumReq-1:0]       req_done_o,
    output logic [NumReq-1:0]       req_busy_o,
    output logic                    idle_o,
    output logic                    spurious_o,
    mempool_dma_scheduler_if.master be
);
    localparam int unsigned IdxWidth = idx_width(NumReq);
    localparam int unsigned CntWidth = cnt_width(MaxOutstanding);

    typedef logic [IdxWidth-1:0] idx_t;
    typedef logic [CntWidth-1:0] cnt_t;

    logic              lock_q;
    idx_t              lock_idx_q, rr_q;
    cnt_t              cnt_q [NumReq];
    cnt_t              cnt_d [NumReq];
    logic [NumReq-1:0] done_q, done_d;
    logic              spurious_q;

    logic [NumReq-1:0] eligible;
    idx_t              rr_idx, grant_idx, fifo_head;
    logic              rr_found, grant_valid, grant_zero, fwd_valid;
    logic              handshake, zero_accept, fifo_full, fifo_empty, fifo_pop;

    // Zero-byte requests wait until the requester has nothing in flight to keep its order.
    always_comb begin
        for (int unsigned i = 0; i < NumReq; i++) begin
            eligible[i] = req_valid_i[i] &
                          ((req_burst_i[i].num_bytes != '0) || (cnt_q[i] == '0));
        end
    end

    always_comb begin
        int unsigned j;
        j        = 0;
        rr_idx   = '0;
        rr_found = 1'b0;
        for (int unsigned off = 0; off < NumReq; off++) begin
            j = off + 32'(rr_q);
            if (j >= NumReq) j = j - NumReq;
            if (!rr_found && eligible[idx_t'(j)]) begin
                rr_found = 1'b1;
                rr_idx   = idx_t'(j);
            end
        end
    end

    always_comb begin
        grant_idx    = lock_q ? lock_idx_q : rr_idx;
        grant_valid  = lock_q | rr_found;
        grant_zero   = grant_valid & (req_burst_i[grant_idx].num_bytes == '0);
        fwd_valid    = grant_valid & ~grant_zero & ~fifo_full;
        handshake    = fwd_valid & be.ready;
        zero_accept  = grant_valid & grant_zero;
        be.valid     = fwd_valid;
        be.burst_req = req_burst_i[grant_idx];
        fifo_pop     = be.trans_complete & ~fifo_empty;
        req_ready_o  = '0;
        if (handshake || zero_accept) req_ready_o[grant_idx] = 1'b1;
    end

    always_comb begin
        for (int unsigned i = 0; i < NumReq; i++) begin
            cnt_d[i] = cnt_q[i];
            if (handshake && (grant_idx == idx_t'(i))) cnt_d[i] = cnt_d[i] + cnt_t'(1);
            if (fifo_pop && (fifo_head == idx_t'(i)))  cnt_d[i] = cnt_d[i] - cnt_t'(1);
            done_d[i]     = (fifo_pop && (fifo_head == idx_t'(i))) ||
                            (zero_accept && (grant_idx == idx_t'(i)));
            req_busy_o[i] = (cnt_q[i] != '0);
        end
    end

    assign req_done_o = done_q;
    assign spurious_o = spurious_q;
    assign idle_o     = fifo_empty & be.backend_idle;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            rr_q       <= '0;
            done_q     <= '0;
            spurious_q <= 1'b0;
            for (int unsigned i = 0; i < NumReq; i++) cnt_q[i] <= '0;
        end else begin
            lock_q     <= fwd_valid & ~be.ready;
            lock_idx_q <= grant_idx;
            if (handshake || zero_accept) begin
                rr_q <= (grant_idx == idx_t'(NumReq - 1)) ? '0 : grant_idx + 1'b1;
            end
            done_q <= done_d;
            if (be.trans_complete && fifo_empty) spurious_q <= 1'b1;
            for (int unsigned i = 0; i < NumReq; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    mempool_dma_sched_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdxWidth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (handshake),
        .data_i  (grant_idx),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_mempool_dma_scheduler.sv
// Randomised and directed bench for mempool_dma_scheduler against a queue-based reference model.
module tb_mempool_dma_scheduler;
    import mempool_dma_scheduler_pkg::*;

    localparam int unsigned NumReq = 4;
    localparam int unsigned MaxOut = 4;

    logic              clk = 1'b0;
    logic              rst;
    burst_req_t        req_burst [NumReq];
    logic [NumReq-1:0] req_valid, req_ready, req_done, req_busy;
    logic              idle, spurious;

    mempool_dma_scheduler_if be_if ();

    mempool_dma_scheduler #(
        .NumReq         (NumReq),
        .MaxOutstanding (MaxOut)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_burst_i (req_burst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_done_o  (req_done),
        .req_busy_o  (req_busy),
        .idle_o      (idle),
        .spurious_o  (spurious),
        .be          (be_if)
    );

    always #5 clk = ~clk;

    int                checks = 0;
    int                errors = 0;
    int                be_out = 0;
    int                tag    = 1;
    logic [NumReq-1:0] acc    = '0;
    burst_req_t        issue_q [$];
    logic [NumReq-1:0] done_q  [$];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding transfers are a queue of requester ids; grant is the first
    // eligible requester counting up from the round-robin pointer.
    initial begin : model
        int                m_ptr, m_lock_id, g, j;
        bit                m_lock, m_spur, gv, zero, ev;
        int                m_fifo [$];
        int                cnt [NumReq];
        logic [NumReq-1:0] m_done, er, bv, nd;
        m_ptr = 0; m_lock = 0; m_lock_id = 0; m_spur = 0; m_done = '0;
        forever begin
            @(negedge clk);
            done_q.push_back(m_done);
            foreach (cnt[i]) cnt[i] = 0;
            foreach (m_fifo[k]) cnt[m_fifo[k]]++;
            gv = 0;
            g  = 0;
            if (m_lock) begin
                gv = 1;
                g  = m_lock_id;
            end else begin
                for (int o = 0; o < NumReq; o++) begin
                    j = (m_ptr + o) % NumReq;
                    if (!gv && req_valid[j] && (req_burst[j].num_bytes != 0 || cnt[j] == 0)) begin
                        gv = 1;
                        g  = j;
                    end
                end
            end
            zero = gv && (req_burst[g].num_bytes == 0);
            ev   = gv && !zero && (m_fifo.size() < MaxOut);
            er   = '0;
            if ((ev && be_if.ready) || zero) er[g] = 1'b1;
            foreach (bv[i]) bv[i] = (cnt[i] != 0);
            chk("valid_o", 96'(be_if.valid), 96'(ev));
            chk("req_ready_o", 96'(req_ready), 96'(er));
            if (ev) chk("burst_req_o", be_if.burst_req, req_burst[g]);
            chk("req_busy_o", 96'(req_busy), 96'(bv));
            chk("idle_o", 96'(idle), 96'(m_fifo.size() == 0 && be_if.backend_idle));
            chk("spurious_o", 96'(spurious), 96'(m_spur));
            if (rst) begin
                m_fifo.delete();
                m_ptr = 0; m_lock = 0; m_lock_id = 0; m_spur = 0; m_done = '0;
            end else begin
                nd = '0;
                if (be_if.trans_complete) begin
                    if (m_fifo.size() > 0) nd[m_fifo.pop_front()] = 1'b1;
                    else m_spur = 1;
                end
                if (zero) nd[g] = 1'b1;
                if (ev && be_if.ready) begin
                    m_fifo.push_back(g);
                    issue_q.push_back(req_burst[g]);
                end
                if ((ev && be_if.ready) || zero) m_ptr = (g + 1) % NumReq;
                m_lock    = ev && !be_if.ready;
                m_lock_id = g;
                m_done    = nd;
            end
        end
    end

    // Monitor: pops expected done vectors every cycle and expected bursts on backend handshakes.
    initial begin : monitor
        logic [NumReq-1:0] exp_done;
        burst_req_t        exp_burst;
        forever begin
            @(negedge clk);
            #1;
            if (done_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL req_done_o: no expected entry at %0t", $time);
            end else begin
                exp_done = done_q.pop_front();
                chk("req_done_o", 96'(req_done), 96'(exp_done));
            end
            if (!rst && be_if.valid && be_if.ready) begin
                if (issue_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL issued_burst: unexpected handshake %0h", be_if.burst_req);
                end else begin
                    exp_burst = issue_q.pop_front();
                    chk("issued_burst", be_if.burst_req, exp_burst);
                end
            end
            acc = req_ready & req_valid;
            if (rst) begin
                be_out = 0;
            end else begin
                if (be_if.trans_complete && be_out > 0) be_out--;
                if (be_if.valid && be_if.ready) be_out++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NumReq; i++) if (acc[i]) req_valid[i] = 1'b0;
    endtask

    task automatic raise(input int i, input logic [31:0] nb);
        req_burst[i] = '{src: 32'(tag), dst: ~32'(tag), num_bytes: nb};
        tag++;
        req_valid[i] = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((req_valid != '0 || be_out != 0) && n < 100) begin
            be_if.trans_complete = (be_out > 0);
            step();
            n++;
        end
        be_if.trans_complete = 1'b0;
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL drain: timed out with valid=%0b outstanding=%0d", req_valid, be_out);
        end
    endtask

    initial begin : stimulus
        rst                  = 1'b1;
        req_valid            = '0;
        foreach (req_burst[i]) req_burst[i] = '0;
        be_if.ready          = 1'b0;
        be_if.trans_complete = 1'b0;
        be_if.backend_idle   = 1'b1;
        repeat (2) step();
        rst = 1'b0;

        // Single request, completed five cycles later.
        raise(2, 64);
        be_if.ready = 1'b1;
        repeat (5) step();
        be_if.trans_complete = 1'b1;
        step();
        be_if.trans_complete = 1'b0;
        repeat (3) step();

        // Fairness with all requesters continuously valid.
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < NumReq; i++) if (!req_valid[i]) raise(i, 64 + i);
            be_if.trans_complete = (be_out > 0);
            step();
        end
        drain();

        // Backpressure: requester 1 locked while requester 0 joins.
        be_if.ready = 1'b0;
        raise(1, 128);
        repeat (3) step();
        raise(0, 256);
        step();
        be_if.ready = 1'b1;
        repeat (2) step();
        drain();

        // Tracking FIFO full, then a single completion frees one slot.
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < NumReq; i++) if (!req_valid[i]) raise(i, 512);
            step();
        end
        be_if.trans_complete = 1'b1;
        step();
        be_if.trans_complete = 1'b0;
        repeat (2) step();
        drain();

        // Zero-byte request held behind an outstanding transfer.
        raise(3, 64);
        step();
        raise(3, 0);
        repeat (3) step();
        be_if.trans_complete = 1'b1;
        step();
        be_if.trans_complete = 1'b0;
        repeat (3) step();
        drain();

        // Reset with two outstanding, then a spurious completion.
        raise(0, 64);
        raise(1, 64);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        be_if.trans_complete = 1'b1;
        step();
        be_if.trans_complete = 1'b0;
        repeat (2) step();

        // Randomised traffic with occasional resets and spurious completions.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NumReq; i++) begin
                if (!req_valid[i] && $urandom_range(2) == 0) begin
                    raise(i, ($urandom_range(4) == 0) ? 32'd0 : 32'($urandom_range(4096, 1)));
                end
            end
            be_if.ready          = ($urandom_range(3) != 0);
            be_if.trans_complete = (be_out > 0) ? ($urandom_range(1) == 1)
                                                : ($urandom_range(60) == 0);
            be_if.backend_idle   = ($urandom_range(3) != 0);
            rst                  = ($urandom_range(300) == 0);
            step();
        end
        rst         = 1'b0;
        be_if.ready = 1'b1;
        drain();
        repeat (2) step();
        chk("issue_queue_empty", 96'(issue_q.size()), 96'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
